// File: rtl/axis_audio_buffer_pkg.sv
// Shared types and width helpers for the playback elastic buffer.
// State encoding and the count-width rule live here so the top and bench agree.
package axis_audio_buffer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_ADDR_WIDTH = 10;

  // Occupancy counters must hold 2^addr_width words plus the output register.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/axis_audio_bram.sv
// Inferred simple dual-port RAM with a registered, enabled read port.
// rd_data holds its value while rd_en is low, so it acts as a prefetch stage.
module axis_audio_bram
  import axis_audio_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  aclk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge aclk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_audio_buffer.sv
// Playback elastic buffer in front of the I2S DAC port: prefill gating,
// one-word output register fed from a registered-read RAM, underrun counting.
module axis_audio_buffer
  import axis_audio_buffer_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int unsigned CNTR_WIDTH       = 32
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [ADDR_WIDTH-1:0]                  cfg_data,
  output logic [count_width(ADDR_WIDTH)-1:0]     sts_count,
  output logic [CNTR_WIDTH-1:0]                  sts_underrun,
  output logic                                   s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                                   s_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]            m_axis_tdata,
  output logic                                   m_axis_tvalid
);

  localparam int unsigned CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] MEM_DEPTH = CW'(2**ADDR_WIDTH);

  state_e                      state_q, state_d;
  logic [CW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic [CNTR_WIDTH-1:0]       underrun_q, underrun_d;
  logic [AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        rd_pend_q, rd_pend_d;
  logic                        m_tvalid_q, m_tvalid_d;
  logic                        s_tready_q, s_tready_d;

  logic [AXIS_TDATA_WIDTH-1:0] ram_rdata;
  logic                        wr_en;
  logic                        rd_en;
  logic                        pop;
  logic                        load;
  logic                        underrun_ev;
  logic [CW-1:0]               unread;
  logic [CW-1:0]               threshold;
  logic [CW-1:0]               mem_words_d;

  axis_audio_bram #(
    .DATA_WIDTH (AXIS_TDATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .aclk    (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (ram_rdata)
  );

  // Handshake decode and RAM prefetch control.
  always_comb begin
    wr_en       = s_axis_tvalid & s_tready_q;
    pop         = m_axis_tready & m_tvalid_q;
    underrun_ev = (state_q == ST_RUN) & m_axis_tready & ~out_valid_q;
    unread      = wr_ptr_q - rd_ptr_q;
    // rd_data is a second holding stage: move it forward whenever the
    // output register frees up, and refill it in the same cycle.
    load        = rd_pend_q & (~out_valid_q | pop);
    rd_en       = (unread != '0) & (~rd_pend_q | load);
    if (cfg_data == '0) begin
      threshold = CW'(1);
    end else begin
      threshold = {1'b0, cfg_data};
    end
  end

  // Pointers, output register and occupancy.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;
    rd_pend_d   = rd_en | (rd_pend_q & ~load);

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (load) begin
      out_data_d  = ram_rdata;
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Words still occupying RAM slots, including one parked in rd_data.
    mem_words_d = count_d - CW'(out_valid_d);
    s_tready_d  = (mem_words_d != MEM_DEPTH);
  end

  // Playback state, underrun counter and registered valid.
  always_comb begin
    state_d    = state_q;
    underrun_d = underrun_q;

    case (state_q)
      ST_FILL: begin
        if (count_q >= threshold) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RUN: begin
        if (underrun_ev) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (underrun_ev && (underrun_q != '1)) begin
      underrun_d = underrun_q + CNTR_WIDTH'(1);
    end else begin
      underrun_d = underrun_q;
    end

    m_tvalid_d = out_valid_d & (state_d == ST_RUN);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underrun_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
      s_tready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underrun_q  <= underrun_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rd_pend_q   <= rd_pend_d;
      m_tvalid_q  <= m_tvalid_d;
      s_tready_q  <= s_tready_d;
    end
  end

  assign sts_count     = count_q;
  assign sts_underrun  = underrun_q;
  assign s_axis_tready = s_tready_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = m_tvalid_q;

endmodule

// File: doc/axis_audio_buffer.md
Name: axis_audio_buffer

Overview:
- Playback elastic buffer that sits directly upstream of the I2S codec block's DAC slave port.
- Absorbs bursty DMA/PS writes of packed stereo words ({left[31:16], right[15:0]}) and serves them at the I2S frame rate.
- The I2S block pulses tready once per frame regardless of tvalid. This buffer therefore applies a prefill threshold before playback starts, and detects and counts underruns.

Parameters:
- AXIS_TDATA_WIDTH, 32, stereo sample word width.
- ADDR_WIDTH, 10, log2 of storage depth (1024 words).
- CNTR_WIDTH, 32, width of the underrun counter.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- cfg_data  in  ADDR_WIDTH  prefill threshold in words; value 0 is treated as 1
- sts_count  out  ADDR_WIDTH+1  words held (memory plus output register)
- sts_underrun  out  CNTR_WIDTH  saturating underrun count
- s_axis_tready  out  1  write side ready
- s_axis_tdata  in  AXIS_TDATA_WIDTH  write data
- s_axis_tvalid  in  1  write valid
- m_axis_tready  in  1  read strobe from I2S (one cycle per frame)
- m_axis_tdata  out  AXIS_TDATA_WIDTH  head sample
- m_axis_tvalid  out  1  head valid

Behaviour:
- Clock and reset: reset aresetn, synchronous, active-low; clock aclk. All state is updated on the aclk rising edge.
- Reset values:
  - sts_count = 0, sts_underrun = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0.
  - s_axis_tready = 1 from the first cycle after reset.
  - State = FILL; memory pointers = 0; out_valid = 0.
- Storage:
  - Simple dual-port RAM, depth 2^ADDR_WIDTH, 1-cycle registered read.
  - Followed by one output register (out_data, out_valid). Total capacity is 2^ADDR_WIDTH + 1.
  - s_axis_tready = ~mem_full, where mem_full means the memory holds 2^ADDR_WIDTH words.
- Write and prefetch:
  - A word is written when s_axis_tvalid & s_axis_tready.
  - Prefetch loads the output register whenever it is empty or being consumed and memory is non-empty. It accounts for the 1-cycle RAM latency.
  - Fall-through: a word written into a completely empty buffer at cycle t has out_valid = 1 at t+2.
  - Back-to-back pops at one per cycle must be sustainable with no bubbles (a RAM read is issued in the same cycle as a pop).
- Handshake:
  - m_axis_tvalid = out_valid & (state == RUN).
  - m_axis_tdata = out_data.
  - A pop occurs on m_axis_tready & m_axis_tvalid.
- sts_count:
  - Increments on a write, decrements on a pop, unchanged when both occur in the same cycle.
  - Registered, updated in the same edge as the event.
- State machine:
  - FILL:
    - Accept writes; m_axis_tvalid is forced to 0.
    - m_axis_tready strobes are ignored and not counted.
    - Go to RUN when sts_count >= max(cfg_data, 1).
  - RUN:
    - Serve pops.
    - If m_axis_tready = 1 while out_valid = 0, this is an underrun: sts_underrun increments (saturating at all-ones) and the state goes to FILL.
    - Writes continue in RUN.
- Simultaneous events:
  - Write plus underrun strobe in the same cycle: the write is stored and the underrun is still counted.
  - The FILL→RUN check uses the updated count, so the threshold is evaluated on the next cycle.
- Threshold limits and changes:
  - A threshold above the capacity never releases playback; this is by design and software must not program it.
  - A cfg_data change while in RUN has no effect until the next FILL.
- Full buffer: s_axis_tready = 0; no overwrite, no data loss.
- Reset mid-operation: all contents are discarded and all outputs return to their reset values on the next edge.

Decomposition:
- Shared package:
  - State encoding (FILL = 1'b0, RUN = 1'b1).
  - Width helper constant for the count width (ADDR_WIDTH+1).
- One natural sub-module: axis_audio_bram, an inferred simple dual-port RAM with registered read, parameters DATA_WIDTH and ADDR_WIDTH.

Test Plan:
- Prefill: cfg_data = 4; write 3 words (0x00010001..0x00030003) while m_axis_tready strobes every 64 cycles -> m_axis_tvalid stays 0 and sts_underrun stays 0. The 4th write -> RUN; the next strobe pops 0x00010001 and sts_count becomes 3.
- Underrun: in RUN, drain all 4 words, then strobe once more -> sts_underrun = 1, state FILL, m_axis_tvalid = 0. Write 4 more words -> playback resumes with the first new word.
- Full: cfg_data = 0, no strobes; write continuously -> s_axis_tready drops after 2^ADDR_WIDTH + 1 accepted words and sts_count = 1025. One pop -> s_axis_tready = 1 within 2 cycles and no word is lost; read back the sequence in order.
- Throughput: m_axis_tready held high, s_axis_tvalid high with an incrementing pattern -> output order is preserved, no duplicates, and one pop per cycle after the initial 2-cycle latency.
- Simultaneous: a write and a pop in the same cycle at sts_count = 5 -> sts_count stays 5. A write plus an underrun strobe on an empty buffer in RUN -> sts_underrun += 1, sts_count = 1, state FILL.
- Reset mid-stream: deassert aresetn with 10 words buffered -> next cycle sts_count = 0, m_axis_tvalid = 0, sts_underrun = 0, s_axis_tready = 1.
